// File: rtl/mux3_arbiter.sv
// +---------------------------------------------------------------------------+
// | mux3_arbiter: round-robin arbiter driving the select of a shared 3:1 mux. |
// | Optional per-holder timeout: MUX3_ARB_TIMEOUT_EN.  Rev 1.0                |
// +---------------------------------------------------------------------------+
`default_nettype none

module mux3_arbiter #(
  parameter int W        = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   req,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  output logic         s0,
  output logic         s1,
  output logic [2:0]   gnt,
  output logic [W-1:0] y,
  output logic         y_valid,
  output logic         busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     last_q, last_d;
  logic [2:0]     gnt_q, gnt_d;
  logic [1:0]     sel_q, sel_d;
  logic [W-1:0]   y_q, y_d;
  logic           y_valid_q, y_valid_d;

  logic [2:0]     others;
  logic [2:0]     cand;
  logic           held;
  logic           expire;
  logic           grant_now;
  logic [1:0]     win;

`ifdef MUX3_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX_C = HOLD_W'(HOLD_MAX);
  logic [HOLD_W-1:0] hold_q, hold_d;
`else
  logic unused_hold_max;
  assign unused_hold_max = (HOLD_MAX < 1);
`endif

  // First asserted bit of m in the order last+1, last+2, last (mod 3).
  function automatic logic [1:0] pick(input logic [2:0] m, input logic [1:0] last);
    logic [1:0] i1;
    logic [1:0] i2;
    i1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    i2 = (last == 2'd0) ? 2'd2 : ((last == 2'd1) ? 2'd0 : 2'd1);
    if (m[i1])      pick = i1;
    else if (m[i2]) pick = i2;
    else            pick = last;
  endfunction

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    grant_now = 1'b0;
    others    = req & ~gnt_q;
    held      = |(req & gnt_q);
    cand      = (state_q == ST_IDLE) ? req : others;
    win       = pick(cand, last_q);
`ifdef MUX3_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    expire    = (hold_q == HOLD_MAX_C) && (|others);
`else
    expire    = 1'b0;
`endif

    if (state_q == ST_IDLE) begin
      grant_now = |req;
    end else if (held && !expire) begin
`ifdef MUX3_ARB_TIMEOUT_EN
      if (hold_q != HOLD_MAX_C) hold_d = hold_q + HOLD_W'(1);
`endif
    end else if (|others) begin
      grant_now = 1'b1;
    end else begin
      // Select lines deliberately keep their last value when going idle.
      state_d = ST_IDLE;
      gnt_d   = 3'b000;
`ifdef MUX3_ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end

    if (grant_now) begin
      state_d = ST_GRANT;
      gnt_d   = 3'b001 << win;
      sel_d   = win;
      last_d  = win;
`ifdef MUX3_ARB_TIMEOUT_EN
      hold_d  = HOLD_W'(1);
`endif
    end

    case (sel_q)
      2'b01:   y_d = x2;
      2'b10:   y_d = x3;
      default: y_d = x1;
    endcase
    y_valid_d = |gnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 2'd2;
      gnt_q     <= 3'b000;
      sel_q     <= 2'b00;
      y_q       <= '0;
      y_valid_q <= 1'b0;
`ifdef MUX3_ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
`ifdef MUX3_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign s1      = sel_q[1];
  assign s0      = sel_q[0];
  assign gnt     = gnt_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = |gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux3_arbiter.sv
// +---------------------------------------------------------------------------+
// | tb_mux3_arbiter: directed self-checking bench for mux3_arbiter.           |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_mux3_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [2:0]   req;
  logic [W-1:0] x1, x2, x3;
  logic         s0, s1;
  logic [2:0]   gnt;
  logic [W-1:0] y;
  logic         y_valid;
  logic         busy;

  int total;
  int bad;

  mux3_arbiter #(.W(W), .HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .s0      (s0),
    .s1      (s1),
    .gnt     (gnt),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] g, input logic [1:0] sel,
                           input logic [W-1:0] yy, input logic yv);
    check({tag, ".gnt"},  32'(gnt), 32'(g));
    check({tag, ".sel"},  32'({s1, s0}), 32'(sel));
    check({tag, ".y"},    32'(y), 32'(yy));
    check({tag, ".yv"},   32'(y_valid), 32'(yv));
    check({tag, ".busy"}, 32'(busy), 32'(|g));
  endtask

  initial begin
    logic [2:0] exp_g;
    logic [2:0] prev_g;
    total = 0;
    bad   = 0;
    x1 = 4'hA;
    x2 = 4'h5;
    x3 = 4'hC;

    // Reset held with all requests asserted
    rst_n = 1'b0;
    req   = 3'b111;
    tick(); tick(); tick();
    check_out("reset", 3'b000, 2'b00, 4'h0, 1'b0);

    // Release: requester 0 wins first; rotation with 2 cycles each
    rst_n = 1'b1;
    tick(); check_out("rel", 3'b001, 2'b00, 4'hA, 1'b0);
    tick(); check_out("rot0b", 3'b001, 2'b00, 4'hA, 1'b1);
    req = 3'b110;
    tick(); check_out("rot1a", 3'b010, 2'b01, 4'hA, 1'b1);
    tick(); check_out("rot1b", 3'b010, 2'b01, 4'h5, 1'b1);
    req = 3'b100;
    tick(); check_out("rot2a", 3'b100, 2'b10, 4'h5, 1'b1);
    tick(); check_out("rot2b", 3'b100, 2'b10, 4'hC, 1'b1);
    req = 3'b000;
    tick(); check_out("rot_idle", 3'b000, 2'b10, 4'hC, 1'b1);
    tick(); check_out("rot_idle2", 3'b000, 2'b10, 4'hC, 1'b0);

    // Single requester 1
    req = 3'b010;
    tick(); check_out("single_g", 3'b010, 2'b01, 4'hC, 1'b0);
    tick(); check_out("single_y", 3'b010, 2'b01, 4'h5, 1'b1);
    req = 3'b000;
    tick(); check_out("single_rel", 3'b000, 2'b01, 4'h5, 1'b1);
    tick(); check_out("single_idle", 3'b000, 2'b01, 4'h5, 1'b0);

    // Simultaneous arrival with last=1: requester 2 before requester 0
    req = 3'b101;
    tick(); check_out("simul_a", 3'b100, 2'b10, 4'h5, 1'b0);
    req = 3'b001;
    tick(); check_out("simul_b", 3'b001, 2'b00, 4'hC, 1'b1);
    req = 3'b000;
    tick(); tick();

    // Reset mid-grant
    req = 3'b100;
    tick(); check_out("mid_g", 3'b100, 2'b10, 4'hA, 1'b0);
    req   = 3'b011;
    rst_n = 1'b0;
    tick(); check_out("mid_rst", 3'b000, 2'b00, 4'h0, 1'b0);
    rst_n = 1'b1;
    tick(); check_out("mid_rel", 3'b001, 2'b00, 4'hA, 1'b0);

    // req=011 held: timeout alternation or permanent hold
    prev_g = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef MUX3_ARB_TIMEOUT_EN
      exp_g = (((k / 4) % 2) == 0) ? 3'b001 : 3'b010;
`else
      exp_g = 3'b001;
`endif
      check($sformatf("hold%0d.gnt", k), 32'(gnt), 32'(exp_g));
      check($sformatf("hold%0d.y", k), 32'(y), 32'((prev_g == 3'b001) ? x1 : x2));
      check($sformatf("hold%0d.yv", k), 32'(y_valid), 32'd1);
      prev_g = exp_g;
    end

    req = 3'b000;
    tick();
    check("end_idle", 32'(gnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
